// File: rtl/s10077_readout_seq.sv
// s10077_readout_seq: S10077 line-sensor frame sequencer.
// Drives SENSOR_CLK/ST, then turns synchronized EOC/EOS edges into pixel strobes and frame status.
module s10077_readout_seq #(
    parameter int DIV       = 8,
    parameter int NPIX      = 1024,
    parameter int MIN_INTEG = 6,
    parameter int TIMEOUT   = 4096
) (
    input  logic        FPGA_CLK,
    input  logic        FPGA_RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic        FREE_RUN,
    input  logic [20:0] INTEG_CLKS,
    input  logic        EOC,
    input  logic        EOS,
    output logic        SENSOR_CLK,
    output logic        ST,
    output logic        BUSY,
    output logic        PIX_STB,
    output logic [10:0] PIX_IDX,
    output logic        FRAME_DONE,
    output logic [10:0] FRAME_LEN,
    output logic        OVF,
    output logic        TIMEOUT_ERR
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    typedef enum logic [1:0] {IDLE, ARM, INTEG, READ} state_t;
    state_t state_q, state_d;
    logic [DW-1:0] div_q;
    logic sclk_q, last, sclk_rise;
    logic [2:0] eoc_q, eos_q;
    logic eoc_e_q, eos_e_q;
    logic [20:0] integ_q, integ_d, cnt_q, cnt_d;
    logic [10:0] pix_q, pix_d, idx_q, idx_d, len_q, len_d;
    logic st_q, st_d, stb_q, stb_d, done_q, done_d, ovf_q, ovf_d, to_q, to_d;
    assign last      = div_q == DW'(DIV - 1);
    assign sclk_rise = last && !sclk_q;
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            eoc_q   <= '0;
            eos_q   <= '0;
            eoc_e_q <= 1'b0;
            eos_e_q <= 1'b0;
        end else begin
            div_q   <= last ? '0 : div_q + 1'b1;
            sclk_q  <= sclk_q ^ last;
            eoc_q   <= {eoc_q[1:0], EOC};
            eos_q   <= {eos_q[1:0], EOS};
            eoc_e_q <= eoc_q[1] & ~eoc_q[2];
            eos_e_q <= eos_q[1] & ~eos_q[2];
        end
    end
    always_comb begin
        state_d = state_q;
        integ_d = integ_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        idx_d   = idx_q;
        len_d   = len_q;
        st_d    = st_q;
        ovf_d   = ovf_q;
        stb_d   = 1'b0;
        done_d  = 1'b0;
        to_d    = 1'b0;
        if (ABORT) begin
            state_d = IDLE;
            st_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (START || FREE_RUN) begin
                    state_d = ARM;
                    integ_d = (INTEG_CLKS < 21'(MIN_INTEG)) ? 21'(MIN_INTEG) : INTEG_CLKS;
                    pix_d   = '0;
                    ovf_d   = 1'b0;
                end
                ARM: if (sclk_rise) begin
                    state_d = INTEG;
                    st_d    = 1'b1;
                    cnt_d   = '0;
                end
                INTEG: if (sclk_rise) begin
                    if (cnt_q == integ_q - 21'd1) begin
                        state_d = READ;
                        st_d    = 1'b0;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + 21'd1;
                end
                READ: begin
                    if (eoc_e_q) begin
                        if (pix_q < 11'(NPIX)) begin
                            stb_d = 1'b1;
                            idx_d = pix_q;
                            pix_d = pix_q + 11'd1;
                        end else ovf_d = 1'b1;
                    end
                    // EOS takes precedence over a timeout expiring on the same cycle
                    if (eos_e_q) begin
                        done_d  = 1'b1;
                        len_d   = pix_d;
                        state_d = IDLE;
                    end else if (sclk_rise) begin
                        if (cnt_q == 21'(TIMEOUT - 1)) begin
                            to_d    = 1'b1;
                            state_d = IDLE;
                        end else cnt_d = cnt_q + 21'd1;
                    end
                end
            endcase
        end
    end
    always_ff @(posedge FPGA_CLK) begin
        if (FPGA_RST) begin
            state_q <= IDLE;
            integ_q <= '0;
            cnt_q   <= '0;
            pix_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            st_q    <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            integ_q <= integ_d;
            cnt_q   <= cnt_d;
            pix_q   <= pix_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            st_q    <= st_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            to_q    <= to_d;
        end
    end
    assign SENSOR_CLK  = sclk_q;
    assign ST          = st_q;
    assign BUSY        = state_q != IDLE;
    assign PIX_STB     = stb_q;
    assign PIX_IDX     = idx_q;
    assign FRAME_DONE  = done_q;
    assign FRAME_LEN   = len_q;
    assign OVF         = ovf_q;
    assign TIMEOUT_ERR = to_q;
endmodule

// File: tb/tb_s10077_readout_seq.sv
// tb_s10077_readout_seq: randomized frames against an event-timestamp model of the sequencer.
// The driver schedules expected output events by cycle; a negedge monitor compares every output.
module tb_s10077_readout_seq;
    localparam int DIV = 8, NPIX = 8, MIN_INTEG = 6, TMO = 32;
    logic FPGA_CLK = 0, FPGA_RST = 1, START = 0, ABORT = 0, FREE_RUN = 0, EOC = 0, EOS = 0;
    logic [20:0] INTEG_CLKS = 0;
    logic SENSOR_CLK, ST, BUSY, PIX_STB, FRAME_DONE, OVF, TIMEOUT_ERR;
    logic [10:0] PIX_IDX, FRAME_LEN;
    int cyc = 0, k = 0;
    bit rst_q = 1;
    int n_chk = 0, n_err = 0;
    int st_rise = 0, st_fall = 0, busy_from = 0, busy_to = 0, to_cyc = -1, ovf_clr = -1, cnt = 0;
    int stb_cyc[$], stb_idx[$], done_cyc[$], done_len[$], ovf_cyc[$];
    int si = 0, di = 0, oi = 0, m_len = 0;
    bit m_ovf = 0, mon_en = 0, fin = 0, fin_done = 0, e_stb, e_done;

    s10077_readout_seq #(.DIV(DIV), .NPIX(NPIX), .MIN_INTEG(MIN_INTEG), .TIMEOUT(TMO)) dut (
        .FPGA_CLK(FPGA_CLK), .FPGA_RST(FPGA_RST), .START(START), .ABORT(ABORT),
        .FREE_RUN(FREE_RUN), .INTEG_CLKS(INTEG_CLKS), .EOC(EOC), .EOS(EOS),
        .SENSOR_CLK(SENSOR_CLK), .ST(ST), .BUSY(BUSY), .PIX_STB(PIX_STB), .PIX_IDX(PIX_IDX),
        .FRAME_DONE(FRAME_DONE), .FRAME_LEN(FRAME_LEN), .OVF(OVF), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 FPGA_CLK = ~FPGA_CLK;

    // cyc numbers every edge; k counts edges since reset, which fixes SENSOR_CLK phase
    always @(posedge FPGA_CLK) begin
        cyc   <= cyc + 1;
        k     <= FPGA_RST ? 0 : k + 1;
        rst_q <= FPGA_RST;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge FPGA_CLK) if (mon_en) begin
        if (rst_q) begin
            m_len = 0;
            m_ovf = 0;
            check("pix_idx_rst", 32'(PIX_IDX), 0);
        end
        if (cyc == ovf_clr) m_ovf = 0;
        if (oi < ovf_cyc.size() && ovf_cyc[oi] == cyc) begin
            m_ovf = 1;
            oi++;
        end
        e_stb  = si < stb_cyc.size() && stb_cyc[si] == cyc;
        e_done = di < done_cyc.size() && done_cyc[di] == cyc;
        check("sclk", 32'(SENSOR_CLK), (k / DIV) % 2);
        check("st", 32'(ST), 32'(cyc >= st_rise && cyc < st_fall));
        check("busy", 32'(BUSY), 32'(cyc >= busy_from && cyc < busy_to));
        check("pix_stb", 32'(PIX_STB), 32'(e_stb));
        if (e_stb) begin
            check("pix_idx", 32'(PIX_IDX), stb_idx[si]);
            si++;
        end
        if (e_done) begin
            m_len = done_len[di];
            di++;
        end
        check("frame_done", 32'(FRAME_DONE), 32'(e_done));
        check("frame_len", 32'(FRAME_LEN), m_len);
        check("ovf", 32'(OVF), 32'(m_ovf));
        check("timeout_err", 32'(TIMEOUT_ERR), 32'(cyc == to_cyc));
        if (fin && !fin_done) begin
            check("stb_all", si, stb_cyc.size());
            check("done_all", di, done_cyc.size());
            check("ovf_all", oi, ovf_cyc.size());
            fin_done = 1;
        end
    end

    task automatic tick();
        @(posedge FPGA_CLK);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // frame accepted at edge ks: ST rises on the first SENSOR_CLK rise after it, for max(ic,MIN) rises
    task automatic arm(input int ks, input logic [20:0] ic);
        int r;
        r = ks + 1;
        while ((r - cyc + k) % (2 * DIV) != DIV) r++;
        st_rise   = r;
        st_fall   = r + ((ic < MIN_INTEG) ? MIN_INTEG : int'(ic)) * 2 * DIV;
        busy_from = ks;
        busy_to   = 1 << 30;
        ovf_clr   = ks;
        cnt       = 0;
    endtask

    task automatic start(input logic [20:0] ic);
        INTEG_CLKS = ic;
        START = 1;
        arm(cyc + 1, ic);
        tick();
        START = 0;
        INTEG_CLKS = 21'($urandom_range(0, 40));
    endtask

    // an input edge sampled at edge n shows on the outputs after edge n+3
    task automatic pulse(input bit e_c, input bit e_s, input bit rd);
        EOC = e_c;
        EOS = e_s;
        if (rd && e_c) begin
            if (cnt < NPIX) begin
                stb_cyc.push_back(cyc + 4);
                stb_idx.push_back(cnt);
                cnt++;
            end else ovf_cyc.push_back(cyc + 4);
        end
        if (rd && e_s) begin
            done_cyc.push_back(cyc + 4);
            done_len.push_back(cnt);
            busy_to = cyc + 4;
        end
        repeat ($urandom_range(1, 3)) tick();
        EOC = 0;
        EOS = 0;
        repeat ($urandom_range(2, 4)) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0;
        bit same;
        repeat (2) tick();
        mon_en = 1;
        tick();
        FPGA_RST = 0;
        repeat (200) tick();
        start(10);
        wait_until(st_fall + 3);
        repeat (5) pulse(1, 0, 1);
        pulse(0, 1, 1);
        repeat (4) tick();
        start(2);
        wait_until(st_rise + 20);
        pulse(1, 0, 0);
        wait_until(st_fall - 4);
        pulse(1, 0, 0);
        pulse(1, 0, 1);
        pulse(0, 1, 1);
        repeat (4) tick();
        start(6);
        wait_until(st_fall);
        repeat (10) pulse(1, 0, 1);
        pulse(0, 1, 1);
        repeat (4) tick();
        start(7);
        wait_until(st_rise + 5);
        START = 1;
        tick();
        START = 0;
        to_cyc  = st_fall + TMO * 2 * DIV;
        busy_to = to_cyc;
        wait_until(to_cyc + 10);
        FREE_RUN = 1;
        INTEG_CLKS = 9;
        arm(cyc + 1, 9);
        tick();
        wait_until(st_fall + 2);
        repeat (3) pulse(1, 0, 1);
        c0 = cyc;
        EOC = 1;
        EOS = 1;
        stb_cyc.push_back(c0 + 4);
        stb_idx.push_back(cnt);
        cnt++;
        done_cyc.push_back(c0 + 4);
        done_len.push_back(cnt);
        busy_to = c0 + 4;
        INTEG_CLKS = 7;
        repeat (2) tick();
        EOC = 0;
        EOS = 0;
        wait_until(c0 + 4);
        arm(c0 + 5, 7);
        wait_until(st_rise + 3 * 2 * DIV);
        ABORT = 1;
        st_fall = cyc + 1;
        busy_to = cyc + 1;
        repeat (10) tick();
        START = 1;
        tick();
        START = 0;
        pulse(1, 1, 0);
        FREE_RUN = 0;
        ABORT = 0;
        repeat (10) tick();
        repeat (15) begin
            n = $urandom_range(0, 11);
            same = 1'($urandom_range(0, 1));
            start(21'($urandom_range(0, 12)));
            if ($urandom_range(0, 1) == 1) begin
                wait_until(st_rise + 2);
                pulse(1, 1'($urandom_range(0, 1)), 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                wait_until(st_rise + 40);
                START = 1;
                tick();
                START = 0;
            end
            wait_until(st_fall - 3 + int'($urandom_range(0, 6)));
            for (int i = 0; i < n; i++) pulse(1, same && i == n - 1, 1);
            if (!same || n == 0) pulse(0, 1, 1);
            repeat (3) tick();
        end
        start(6);
        wait_until(st_fall);
        repeat (9) pulse(1, 0, 1);
        repeat (3) tick();
        FPGA_RST = 1;
        busy_to = cyc + 1;
        repeat (2) tick();
        FPGA_RST = 0;
        repeat (40) tick();
        fin = 1;
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
